// File: rtl/ext_mem_responder_pkg.sv
// Shared definitions for the external memory responder: FSM encoding,
// default latency and the address range check.
package ext_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int DEFAULT_LATENCY = 4;

    // Any address bit above the word index makes the access out of range.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_bits);
        return (addr >> (addr_bits + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Single-port word-addressed synchronous RAM with registered read data.
// Contents are never cleared.
module ext_mem_array #(
    parameter int    WORD_SIZE = 32,
    parameter int    ADDR_BITS = 12,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ext_mem_responder.sv
// Memory responder: accepts one word read/write per request and answers with
// a one-cycle mem_ready pulse a fixed LATENCY cycles after acceptance.
//
// state | meaning
// IDLE  | waiting; a request at the edge is latched and accepted
// BUSY  | latency countdown; dropped request aborts, zero count performs access
// ACK   | mem_ready (and mem_err / read data) presented for this one cycle
module ext_mem_responder
    import ext_mem_responder_pkg::*;
#(
    parameter int    WORD_SIZE = 32,
    parameter int    ADDR_BITS = 12,
    parameter int    LATENCY   = DEFAULT_LATENCY,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          mem_addr,
    input  logic                 en_ext_mem_re,
    input  logic                 en_ext_mem_wr,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 mem_ready,
    output logic                 mem_err
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t               state;
    logic [7:0]           cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_SIZE-1:0] data_q;
    logic                 wr_q;
    logic                 err_q;

    logic                 req;
    logic                 range_err;
    logic [ADDR_BITS-1:0] idx_in;
    logic [ADDR_BITS-1:0] ram_addr;
    logic                 ram_we;
    logic [WORD_SIZE-1:0] ram_rdata;
    logic                 unused_byte_offset;

    assign req                = en_ext_mem_re | en_ext_mem_wr;
    assign idx_in             = mem_addr[ADDR_BITS+1:2];
    assign range_err          = addr_out_of_range(mem_addr, ADDR_BITS);
    assign unused_byte_offset = ^mem_addr[1:0];

    // In IDLE the RAM already reads the incoming index so that LATENCY=1
    // still has valid read data at the edge into ACK.
    assign ram_addr = (state == ST_IDLE) ? idx_in : addr_q;
    assign ram_we   = (state == ST_BUSY) && req && (cnt == 8'd0) && wr_q && !err_q;

    ext_mem_array #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            data_out  <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            data_out  <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q <= idx_in;
                        data_q <= data_in;
                        wr_q   <= en_ext_mem_wr;
                        err_q  <= range_err;
                        cnt    <= CNT_LOAD;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state     <= ST_ACK;
                        mem_ready <= 1'b1;
                        mem_err   <= err_q;
                        data_out  <= (wr_q || err_q) ? '0 : ram_rdata;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Scoreboard bench: drivers push expected responses, monitors pop and compare
// on every mem_ready pulse. Instance a uses LATENCY=4, instance b LATENCY=1.
module tb_ext_mem_responder;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];

    logic [31:0] addr_a = '0, din_a = '0, dout_a;
    logic        re_a = 1'b0, wr_a = 1'b0, rdy_a, err_a;
    logic [31:0] addr_b = '0, din_b = '0, dout_b;
    logic        re_b = 1'b0, wr_b = 1'b0, rdy_b, err_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ext_mem_responder #(.WORD_SIZE(32), .ADDR_BITS(12), .LATENCY(LAT_A), .INIT_FILE("")) dut_a (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr_a), .en_ext_mem_re(re_a),
        .en_ext_mem_wr(wr_a), .data_in(din_a), .data_out(dout_a),
        .mem_ready(rdy_a), .mem_err(err_a)
    );

    ext_mem_responder #(.WORD_SIZE(32), .ADDR_BITS(12), .LATENCY(LAT_B), .INIT_FILE("")) dut_b (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr_b), .en_ext_mem_re(re_b),
        .en_ext_mem_wr(wr_b), .data_in(din_b), .data_out(dout_b),
        .mem_ready(rdy_b), .mem_err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (rdy_a) begin
            if (q_a.size() == 0) begin
                fail_now("a_unexpected_ready");
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_data", dout_a, e.data);
                check("a_err", {31'd0, err_a}, {31'd0, e.err});
                check("a_ready_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rdy_b) begin
            if (q_b.size() == 0) begin
                fail_now("b_unexpected_ready");
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_data", dout_b, e.data);
                check("b_err", {31'd0, err_b}, {31'd0, e.err});
                check("b_ready_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one request on instance a; optionally change addr/data once BUSY.
    task automatic req_a(input logic [31:0] addr, input logic re, input logic wr,
                         input logic [31:0] din, input logic [31:0] exp_data,
                         input logic exp_err, input logic chg, input logic [31:0] alt_addr);
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        addr_a = addr; re_a = re; wr_a = wr; din_a = din;
        q_a.push_back('{data: exp_data, err: exp_err, cyc: cyc + 1 + LAT_A});
        if (chg) begin
            @(posedge clk); #1;
            addr_a = alt_addr; din_a = ~din;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy_a) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("a_req_timeout");
        re_a = 1'b0; wr_a = 1'b0;
    endtask

    task automatic abort_a(input logic [31:0] addr, input logic [31:0] din);
        @(posedge clk); #1;
        addr_a = addr; wr_a = 1'b1; din_a = din;
        @(posedge clk);
        @(posedge clk); #1;
        wr_a = 1'b0;
        repeat (LAT_A + 3) @(posedge clk);
    endtask

    // Request held through ACK on instance b. IDLE always takes one cycle,
    // so held requests complete every LATENCY+2 cycles.
    task automatic held_b(input logic re, input logic wr, input logic [31:0] exp_data);
        int n;
        n = 0;
        @(posedge clk); #1;
        addr_b = 32'h8; re_b = re; wr_b = wr; din_b = 32'h0F0F_0F0F;
        for (int k = 0; k < 3; k++)
            q_b.push_back('{data: exp_data, err: 1'b0, cyc: cyc + 1 + LAT_B + k * (LAT_B + 2)});
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (rdy_b) n++;
        end
        if (n < 3) fail_now("b_held_timeout");
        re_b = 1'b0; wr_b = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ready", {31'd0, rdy_a}, 32'd0);
        check("rst_a_err", {31'd0, err_a}, 32'd0);
        check("rst_a_data", dout_a, 32'd0);
        check("rst_b_ready", {31'd0, rdy_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        req_a(32'h10, 0, 1, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        req_a(32'h10, 1, 0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);

        req_a(32'h20, 1, 1, 32'h1234_5678, 32'h0, 0, 0, 0);
        req_a(32'h20, 1, 0, 32'h0, 32'h1234_5678, 0, 0, 0);

        req_a(32'h40, 0, 1, 32'h1111_2222, 32'h0, 0, 0, 0);
        abort_a(32'h40, 32'hAAAA_5555);
        req_a(32'h40, 1, 0, 32'h0, 32'h1111_2222, 0, 0, 0);

        req_a(32'h0, 0, 1, 32'h0BAD_C0DE, 32'h0, 0, 0, 0);
        req_a(32'h4000, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        req_a(32'h4000, 0, 1, 32'hCAFE_F00D, 32'h0, 1, 0, 0);
        req_a(32'h0, 1, 0, 32'h0, 32'h0BAD_C0DE, 0, 0, 0);
        req_a(32'h3, 1, 0, 32'h0, 32'h0BAD_C0DE, 0, 0, 0);
        req_a(32'h8000_0000, 1, 0, 32'h0, 32'h0, 1, 0, 0);
        req_a(32'h3FFC, 0, 1, 32'h7654_3210, 32'h0, 0, 0, 0);
        req_a(32'h3FFC, 1, 0, 32'h0, 32'h7654_3210, 0, 0, 0);

        req_a(32'h84, 0, 1, 32'h0101_0101, 32'h0, 0, 0, 0);
        req_a(32'h10, 1, 0, 32'h0, 32'hDEAD_BEEF, 0, 1, 32'h20);
        req_a(32'h80, 0, 1, 32'hA5A5_A5A5, 32'h0, 0, 1, 32'h84);
        req_a(32'h80, 1, 0, 32'h0, 32'hA5A5_A5A5, 0, 0, 0);
        req_a(32'h84, 1, 0, 32'h0, 32'h0101_0101, 0, 0, 0);

        // Reset while a write to 0x10 is counting down.
        @(posedge clk); #1;
        addr_a = 32'h10; wr_a = 1'b1; din_a = 32'h5555_5555;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy_ready", {31'd0, rdy_a}, 32'd0);
        check("rst_busy_data", dout_a, 32'd0);
        wr_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_a(32'h10, 1, 0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);

        // Reset during ACK must clear the outputs without waiting for a clock.
        seen = 0;
        @(posedge clk); #1;
        addr_a = 32'h20; re_a = 1'b1;
        q_a.push_back('{data: 32'h1234_5678, err: 1'b0, cyc: cyc + 1 + LAT_A});
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy_a) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now("a_ack_timeout");
        #1;
        rst_n = 1'b0;
        re_a = 1'b0;
        #1;
        check("rst_ack_ready", {31'd0, rdy_a}, 32'd0);
        check("rst_ack_data", dout_a, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        held_b(0, 1, 32'h0);
        held_b(1, 0, 32'h0F0F_0F0F);

        repeat (10) @(posedge clk);
        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
